uart1_rx: RTL and testbench
===========================

// Module: uart1_rx
// PURPOSE
//   Serial receiver at the far end of the UART1 link. Recovers 8N1 frames
//   from serial_in: idle high, start 0, DATA_BITS data LSB first, stop 1.
//   Samples each bit at its midpoint, presents the byte on rx_data with a
//   one-cycle rx_valid strobe, and flags framing errors. Sits between the
//   pin/loopback wire and the parallel consumer.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per bit period; legal range >= 2
//   DATA_BITS     8   data bits per frame
// PORTS
//   clk        in   1          rising-edge clock, single clock domain
//   rst        in   1          asynchronous, active-low reset (0 = reset)
//   serial_in  in   1          async serial line, idle high
//   rx_data    out  DATA_BITS  last good byte; held until the next good frame
//   rx_valid   out  1          1-cycle pulse: rx_data updated this cycle
//   frame_err  out  1          1-cycle pulse: stop bit sampled as 0
//   busy       out  1          1 while state != IDLE
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, sync flops=1, bit_cnt=0,
//     clk_cnt=0, shift=0, rx_data=0, rx_valid=0, frame_err=0, busy=0.
//     Reset mid-frame aborts the frame; no output pulse is produced.
//   Input path: 2-flop synchronizer; the FSM sees only rx_s, which lags
//     serial_in by 2 cycles.
//   clk_cnt width is $clog2(CLKS_PER_BIT); bit_cnt width is
//     $clog2(DATA_BITS+1). HALF = CLKS_PER_BIT/2 (integer division).
//   FSM:
//     IDLE: rx_s==0 -> START, clk_cnt=0.
//     START: count to HALF-1, then re-sample. rx_s==0 -> DATA with
//       clk_cnt=0 and bit_cnt=0. rx_s==1 -> glitch; return to IDLE with
//       no pulse.
//     DATA: when clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift MSB
//       (shift right, so the first bit received ends up as the LSB),
//       bit_cnt++, clk_cnt=0. After DATA_BITS samples -> STOP.
//     STOP: sample at clk_cnt==CLKS_PER_BIT-1.
//       rx_s==1: rx_data<=shift, rx_valid=1 for one cycle, -> IDLE.
//       rx_s==0: frame_err=1 for one cycle, rx_data unchanged,
//         -> WAIT_IDLE.
//     WAIT_IDLE: stay until rx_s==1 (break/stuck-low line), then -> IDLE.
//       No start bit is detected in this state.
//   Latency: rx_valid rises 2 + HALF + (DATA_BITS+1)*CLKS_PER_BIT cycles
//     after the start-bit falling edge on serial_in, +-1 cycle.
//   Back-to-back frames: IDLE is re-entered at the stop-bit midpoint, so
//     a start bit arriving immediately after the stop bit is accepted.
//   rx_valid and frame_err are never high in the same cycle. Both are
//     registered outputs.
// STRUCTURE
//   uart_pkg: state enum (IDLE, START, DATA, STOP, WAIT_IDLE),
//     UART_IDLE_LEVEL=1'b1, default DATA_BITS.
//   Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1. The
//     FSM, counters and shift register are in uart1_rx.
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8 unless stated)
//   1 Reset release, line idle high -> all outputs 0 and busy=0 for
//     100 cycles.
//   2 Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> exactly one rx_valid
//     pulse with rx_data=8'hA5; frame_err stays 0; busy falls afterwards.
//   3 Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses,
//     rx_data=8'h00 then 8'hFF; pulse spacing is 10*CLKS_PER_BIT.
//   4 serial_in low for 1 clk only (glitch) -> no rx_valid, no frame_err;
//     busy=1 for at most HALF+3 cycles.
//   5 Frame 0x3C with stop bit 0, line held low for 20 cycles, then a good
//     0x81 -> one frame_err pulse; rx_data keeps its previous value; no
//     start is detected while the line is low; then rx_valid with 8'h81.
//   6 Pull rst low during data bit 4, release, send 0x5A -> no pulse for
//     the aborted frame, outputs 0 during reset, then rx_valid with 8'h5A.
//     Repeat cases 2 and 3 with CLKS_PER_BIT=2 and CLKS_PER_BIT=7.

Source files
------------

// File: rtl/uart1_rx_pkg.sv
// Shared types and constants for the UART1 serial receiver.
package uart1_rx_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Level of an idle (marking) serial line.
  localparam logic UART_IDLE_LEVEL = 1'b1;

  localparam int unsigned DEFAULT_DATA_BITS    = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  // Offset from the start-bit edge to its midpoint, in clk cycles.
  function automatic int unsigned half_period(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart1_rx_if.sv
// Receiver-side bundle: serial line in, parallel byte and status out.
interface uart1_rx_if
  import uart1_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
);

  logic                 serial_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  // Receiver drives the parallel side and listens to the line.
  modport master (
    input  serial_in,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  // Line driver / parallel consumer.
  modport slave (
    output serial_in,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart1_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle level.
module uart1_rx_sync
  import uart1_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset to the marking level so no false start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= UART_IDLE_LEVEL;
      q    <= UART_IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart1_rx.sv
// UART1 8N1 receiver: mid-bit sampling, one-cycle valid / framing-error pulses.
module uart1_rx
  import uart1_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
)(
  input  logic       clk,
  input  logic       rst,
  uart1_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF  = half_period(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;

  logic half_hit;
  logic bit_hit;

  // Bring the serial line into the clk domain.
  uart1_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.serial_in),
    .q   (rx_s)
  );

  assign half_hit = (clk_cnt_q == HALF_LAST);
  assign bit_hit  = (clk_cnt_q == BIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_s != UART_IDLE_LEVEL) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (half_hit) begin
          state_d = (rx_s == UART_IDLE_LEVEL) ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_hit && (bit_cnt_q == DATA_LAST)) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at the stop-bit midpoint so a back-to-back start is caught.
        if (bit_hit) begin
          state_d = (rx_s == UART_IDLE_LEVEL) ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // A broken frame or a break: wait for the line to mark again.
        if (rx_s == UART_IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      ST_START: begin
        if (half_hit) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          // LSB arrives first, so shift right and insert at the MSB.
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          clk_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          clk_cnt_d = '0;
          if (rx_s == UART_IDLE_LEVEL) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        clk_cnt_d = '0;
      end
      default: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart1_rx.sv
// Self-checking bench for uart1_rx at CLKS_PER_BIT = 4, 2 and 7.
module tb_uart1_rx;

  logic clk = 1'b0;
  logic rst;
  logic ser [3];

  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart1_rx_if #(.DATA_BITS(8)) if4 ();
  uart1_rx_if #(.DATA_BITS(8)) if2 ();
  uart1_rx_if #(.DATA_BITS(8)) if7 ();

  assign if4.serial_in = ser[0];
  assign if2.serial_in = ser[1];
  assign if7.serial_in = ser[2];

  uart1_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_rx4 (.clk(clk), .rst(rst), .bus(if4.master));
  uart1_rx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) u_rx2 (.clk(clk), .rst(rst), .bus(if2.master));
  uart1_rx #(.CLKS_PER_BIT(7), .DATA_BITS(8)) u_rx7 (.clk(clk), .rst(rst), .bus(if7.master));

  // Observed pulses.
  logic [7:0]  got_data [3][64];
  int unsigned got_cyc  [3][64];
  int          got_n    [3];
  int          fe_n     [3];
  int          busy_cyc [3];
  int          both_n   = 0;
  int          hold_err = 0;
  logic [7:0]  prev_d   [3];

  // Reference model: bytes expected from well-formed frames, framing errors.
  logic [7:0]  exp_data  [3][64];
  int unsigned start_cyc [3][64];
  int          exp_n     [3];
  int          exp_fe    [3];
  int          chk_idx   [3];

  int tests = 0;
  int fails = 0;

  logic       mv [3];
  logic       mf [3];
  logic       mb [3];
  logic [7:0] md [3];

  function automatic int cpb_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 7;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0:       return if4.busy;
      1:       return if2.busy;
      default: return if7.busy;
    endcase
  endfunction

  function automatic logic [7:0] data_of(input int k);
    case (k)
      0:       return if4.rx_data;
      1:       return if2.rx_data;
      default: return if7.rx_data;
    endcase
  endfunction

  // Record pulses away from the active edge.
  always @(negedge clk) begin
    mv[0] = if4.rx_valid;  mf[0] = if4.frame_err;  mb[0] = if4.busy;  md[0] = if4.rx_data;
    mv[1] = if2.rx_valid;  mf[1] = if2.frame_err;  mb[1] = if2.busy;  md[1] = if2.rx_data;
    mv[2] = if7.rx_valid;  mf[2] = if7.frame_err;  mb[2] = if7.busy;  md[2] = if7.rx_data;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        if (mv[k]) begin
          if (got_n[k] < 64) begin
            got_data[k][got_n[k]] = md[k];
            got_cyc[k][got_n[k]]  = cyc;
          end
          got_n[k]++;
        end
        if (mf[k]) fe_n[k]++;
        if (mb[k]) busy_cyc[k]++;
        if (mv[k] && mf[k]) both_n++;
        if (!mv[k] && (md[k] !== prev_d[k])) hold_err++;
      end
      prev_d[k] = md[k];
    end
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, k, obs, exp_v);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; the line is left at the stop-bit level.
  task automatic send_frame(input int k, input logic [7:0] b, input logic stop_bit);
    int c;
    c = cpb_of(k);
    if (stop_bit) begin
      exp_data[k][exp_n[k]]  = b;
      start_cyc[k][exp_n[k]] = cyc;
      exp_n[k]++;
    end else begin
      exp_fe[k]++;
    end
    ser[k] = 1'b0;
    hold(c);
    for (int i = 0; i < 8; i++) begin
      ser[k] = b[i];
      hold(c);
    end
    ser[k] = stop_bit;
    hold(c);
  endtask

  // Wait (bounded) for the model's pulses, then compare bytes and latency.
  task automatic wait_rx(input int k);
    int budget;
    int c;
    int unsigned lat;
    int unsigned e;
    budget = 0;
    c = cpb_of(k);
    while ((got_n[k] < exp_n[k] || fe_n[k] < exp_fe[k]) && budget < 4000) begin
      hold(1);
      budget++;
    end
    hold(2);
    chk("rx_count", k, 32'(got_n[k]), 32'(exp_n[k]));
    chk("fe_count", k, 32'(fe_n[k]), 32'(exp_fe[k]));
    for (int i = chk_idx[k]; i < exp_n[k] && i < got_n[k]; i++) begin
      chk("rx_data", k, 32'(got_data[k][i]), 32'(exp_data[k][i]));
      lat = got_cyc[k][i] - start_cyc[k][i];
      e   = 32'(2 + c / 2 + 9 * c);
      chk("latency", k, ((lat + 1 >= e) && (lat <= e + 1)) ? e : lat, e);
    end
    chk_idx[k] = exp_n[k];
  endtask

  initial begin
    int c;
    int n0;
    logic [7:0] prev;
    logic [7:0] rb;
    logic [7:0] ab;

    for (int k = 0; k < 3; k++) begin
      ser[k] = 1'b1;  got_n[k] = 0;  fe_n[k] = 0;  busy_cyc[k] = 0;
      prev_d[k] = 8'h00;  exp_n[k] = 0;  exp_fe[k] = 0;  chk_idx[k] = 0;
    end
    rst = 1'b0;
    hold(3);
    chk("reset_outputs", 0, 32'({if4.rx_data, if4.rx_valid, if4.frame_err, if4.busy}), 32'h0);
    rst = 1'b1;

    // Idle line after reset: nothing happens.
    hold(100);
    for (int k = 0; k < 3; k++) begin
      chk("idle_valid", k, 32'(got_n[k]), 32'h0);
      chk("idle_ferr", k, 32'(fe_n[k]), 32'h0);
      chk("idle_busy", k, 32'(busy_cyc[k]), 32'h0);
      chk("idle_data", k, 32'(data_of(k)), 32'h0);
    end

    // Single frame 0xA5, then back-to-back 0x00 / 0xFF, at every bit rate.
    for (int k = 0; k < 3; k++) begin
      c = cpb_of(k);
      send_frame(k, 8'hA5, 1'b1);
      ser[k] = 1'b1;
      wait_rx(k);
      hold(3 * c);
      chk("busy_after", k, 32'(busy_of(k)), 32'h0);

      n0 = got_n[k];
      send_frame(k, 8'h00, 1'b1);
      send_frame(k, 8'hFF, 1'b1);
      ser[k] = 1'b1;
      wait_rx(k);
      chk("b2b_spacing", k, got_cyc[k][n0 + 1] - got_cyc[k][n0], 32'(10 * c));
      chk("b2b_last", k, 32'(data_of(k)), 32'hFF);
    end

    // Random bytes with random (possibly zero) idle gaps.
    for (int k = 0; k < 3; k++) begin
      c = cpb_of(k);
      repeat (4) begin
        rb = 8'($urandom);
        send_frame(k, rb, 1'b1);
        ser[k] = 1'b1;
        hold($urandom_range(0, 2 * c));
      end
      wait_rx(k);
    end

    // One-cycle glitch low: brief busy, no pulses.
    c = cpb_of(0);
    hold(2 * c);
    busy_cyc[0] = 0;
    ser[0] = 1'b0;
    hold(1);
    ser[0] = 1'b1;
    hold(20);
    chk("glitch_valid", 0, 32'(got_n[0]), 32'(exp_n[0]));
    chk("glitch_ferr", 0, 32'(fe_n[0]), 32'(exp_fe[0]));
    chk("glitch_busy", 0,
        ((busy_cyc[0] >= 1) && (busy_cyc[0] <= c / 2 + 3)) ? 32'h1 : 32'(busy_cyc[0]), 32'h1);

    // Bad stop bit followed by a stuck-low line, then a good frame.
    prev = exp_data[0][exp_n[0] - 1];
    send_frame(0, 8'h3C, 1'b0);
    hold(20);
    chk("break_busy", 0, 32'(busy_of(0)), 32'h1);
    chk("break_valid", 0, 32'(got_n[0]), 32'(exp_n[0]));
    ser[0] = 1'b1;
    hold(3 * c);
    chk("ferr_count", 0, 32'(fe_n[0]), 32'(exp_fe[0]));
    chk("ferr_data_kept", 0, 32'(data_of(0)), 32'(prev));
    send_frame(0, 8'h81, 1'b1);
    ser[0] = 1'b1;
    wait_rx(0);

    // Reset during data bit 4 aborts the frame silently.
    ab = 8'hC3;
    ser[0] = 1'b0;
    hold(c);
    for (int i = 0; i < 4; i++) begin
      ser[0] = ab[i];
      hold(c);
    end
    ser[0] = ab[4];
    hold(c / 2);
    rst = 1'b0;
    #1;
    chk("midframe_reset", 0, 32'({if4.rx_data, if4.rx_valid, if4.frame_err, if4.busy}), 32'h0);
    ser[0] = 1'b1;
    hold(5);
    rst = 1'b1;
    hold(3 * c);
    chk("abort_valid", 0, 32'(got_n[0]), 32'(exp_n[0]));
    chk("abort_ferr", 0, 32'(fe_n[0]), 32'(exp_fe[0]));
    send_frame(0, 8'h5A, 1'b1);
    ser[0] = 1'b1;
    wait_rx(0);

    chk("valid_and_ferr", 0, 32'(both_n), 32'h0);
    chk("data_hold", 0, 32'(hold_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
